// File: rtl/scan_pkg.sv
// Shared widths and helpers for the four-digit display scan controller.
package scan_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned WORD_W  = 16;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [WORD_W-1:0]  word_t;

    // Prescaler counter width for a given slot length; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        cnt_width = (div > 1) ? $clog2(div) : 1;
    endfunction

    // Nibble of digit idx within a display word (digit 0 in the low nibble).
    function automatic digit_t digit_slice(input word_t word, input idx_t idx);
        digit_slice = word[{idx, 2'b00} +: DIGIT_W];
    endfunction

endpackage

// File: rtl/scan_presc.sv
// Slot prescaler: counts 0..DIV-1 while enabled and flags the last cycle of a slot.
module scan_presc
    import scan_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    output logic [cnt_width(DIV)-1:0]   cnt,
    output logic                        slot_end_c
);

    localparam int unsigned CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d      = cnt_q;
        slot_end_c = en && (cnt_q == CNT_MAX);
        if (slot_end_c) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/scan_ctrl.sv
// Four-digit multiplexed display scanner with frame-aligned word commit.
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic        sel_a,
    output logic        sel_b,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK);
    localparam idx_t LAST_IDX = idx_t'(DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic             slot_end_c;

    idx_t  idx_q,  idx_d;
    word_t act_q,  act_d;
    word_t pend_q, pend_d;
    logic  pv_q,   pv_d;
    logic  tick_q, tick_d;

    logic  wrap_c;
    logic  xfer_c;
    logic  commit_c;

    scan_presc #(
        .DIV        (DIV)
    ) u_presc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cnt        (cnt),
        .slot_end_c (slot_end_c)
    );

    // Transfer needs an empty pending slot and commit needs a full one, so they never collide.
    always_comb begin
        idx_d    = idx_q;
        act_d    = act_q;
        pend_d   = pend_q;
        pv_d     = pv_q;
        wrap_c   = slot_end_c && (idx_q == LAST_IDX);
        xfer_c   = load_valid && !pv_q;
        commit_c = pv_q && (wrap_c || !en);
        tick_d   = wrap_c;

        if (slot_end_c) begin
            idx_d = idx_q + idx_t'(1);
        end
        if (commit_c) begin
            act_d = pend_q;
            pv_d  = 1'b0;
        end
        if (xfer_c) begin
            pend_d = word_t'(load_data);
            pv_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            act_q  <= '0;
            pend_q <= '0;
            pv_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            tick_q <= tick_d;
        end
    end

    assign sel_a      = idx_q[1];
    assign sel_b      = idx_q[0];
    assign digit      = digit_slice(act_q, idx_q);
    assign blank      = !en || (cnt < BLANK_CNT);
    assign frame_tick = tick_q;
    assign load_ready = !pv_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl (DIV=4, BLANK=1 plus a BLANK=0 instance).
module tb_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;

    logic        load_ready, sel_a, sel_b, blank, frame_tick;
    logic [3:0]  digit;
    logic        b0_load_ready, b0_sel_a, b0_sel_b, b0_blank, b0_frame_tick;
    logic [3:0]  b0_digit;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .digit      (digit),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    scan_ctrl #(.DIV(DIV), .BLANK(0)) dut_b0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (b0_load_ready),
        .sel_a      (b0_sel_a),
        .sel_b      (b0_sel_b),
        .digit      (b0_digit),
        .blank      (b0_blank),
        .frame_tick (b0_frame_tick)
    );

    // Behavioural model: words go through a scoreboard queue from transfer to commit.
    int          m_cnt = 0;
    logic [1:0]  m_idx = 2'd0;
    logic [15:0] m_act = 16'h0;
    logic        m_pv = 1'b0;
    logic        m_ft = 1'b0;
    logic [15:0] sb_q[$];
    logic [15:0] m_sh;
    logic [8:0]  m_exp, m_got;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_idx = 2'd0; m_act = 16'h0; m_pv = 1'b0; m_ft = 1'b0;
            sb_q.delete();
        end
        m_sh  = m_act >> (4 * int'(m_idx));
        m_exp = {m_idx, m_sh[3:0], (!en || (m_cnt < int'(BLANK))), m_ft, !m_pv};
        m_got = {sel_a, sel_b, digit, blank, frame_tick, load_ready};
        n_vec++;
        if (m_got !== m_exp) begin
            n_err++;
            $display("FAIL monitor t=%0t {sel,digit,blank,tick,ready} got=%b exp=%b", $time, m_got, m_exp);
        end
        if (rst_n) begin
            if (m_pv && (!en || (m_cnt == int'(DIV) - 1 && m_idx == 2'd3))) begin
                m_act = sb_q.pop_front();
                m_pv  = 1'b0;
            end else if (load_valid && !m_pv) begin
                sb_q.push_back(load_data);
                m_pv = 1'b1;
            end
            m_ft = en && (m_cnt == int'(DIV) - 1) && (m_idx == 2'd3);
            if (en) begin
                if (m_cnt == int'(DIV) - 1) begin
                    m_cnt = 0;
                    m_idx = m_idx + 2'd1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_word(input logic [15:0] w);
        logic r;
        bit   done;
        done = 0;
        load_valid = 1'b1;
        load_data  = w;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            r = load_ready;
            step();
            if (r) begin
                load_valid = 1'b0;
                done = 1;
            end
        end
        n_vec++;
        if (!done) begin
            n_err++;
            load_valid = 1'b0;
            $display("FAIL load_word %h: load_ready got 0 for 64 cycles, required 1", w);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({sel_a, sel_b, digit, blank, frame_tick, load_ready} !== 9'b00_0000_1_0_1) begin
            n_err++;
            $display("FAIL reset_outputs got=%b required=%b",
                     {sel_a, sel_b, digit, blank, frame_tick, load_ready}, 9'b00_0000_1_0_1);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [6:0] exp_v;
        load_word(16'h4321);
        step();
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_v = {2'(k / 4), 4'(k / 4 + 1), (k % 4 == 0)};
            n_vec++;
            if ({sel_a, sel_b, digit, blank} !== exp_v) begin
                n_err++;
                $display("FAIL free_run k=%0d {sel,digit,blank} got=%b required=%b",
                         k, {sel_a, sel_b, digit, blank}, exp_v);
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        repeat (5) step();
        load_word(16'h9999);
        n_vec++;
        if (digit !== 4'h2 || load_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pre_reset digit/ready got=%h/%b required=2/0", digit, load_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({sel_a, sel_b, digit, blank, frame_tick, load_ready} !== 9'b00_0000_1_0_1) begin
            n_err++;
            $display("FAIL reset_mid got=%b required=%b",
                     {sel_a, sel_b, digit, blank, frame_tick, load_ready}, 9'b00_0000_1_0_1);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_vec++;
            if (digit !== 4'h0 || load_ready !== 1'b1) begin
                n_err++;
                $display("FAIL pend_discard k=%0d digit/ready got=%h/%b required=0/1", k, digit, load_ready);
            end
        end
        step();
    endtask

    task automatic test_frame_commit();
        int ticks;
        rst_n = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1;
        load_word(16'h4321);
        step();
        en = 1'b1;
        repeat (4) step();
        load_word(16'hABCD);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            n_vec++;
            if ({sel_a, sel_b, digit, load_ready, frame_tick} !== {2'((5 + k) / 4), 4'((5 + k) / 4 + 1), 2'b00}) begin
                n_err++;
                $display("FAIL old_frame k=%0d {sel,digit,ready,tick} got=%b required=%b", k,
                         {sel_a, sel_b, digit, load_ready, frame_tick}, {2'((5 + k) / 4), 4'((5 + k) / 4 + 1), 2'b00});
            end
        end
        ticks = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
            n_vec++;
            if ({sel_a, sel_b, digit, load_ready, frame_tick} !== {2'(k / 4), 4'(13 - k / 4), 1'b1, (k == 0)}) begin
                n_err++;
                $display("FAIL new_frame k=%0d {sel,digit,ready,tick} got=%b required=%b", k,
                         {sel_a, sel_b, digit, load_ready, frame_tick}, {2'(k / 4), 4'(13 - k / 4), 1'b1, (k == 0)});
            end
        end
        n_vec++;
        if (ticks != 1) begin
            n_err++;
            $display("FAIL tick_count got=%0d required=1", ticks);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  acc0, acc1, w;
        logic r, exp_r;
        acc0 = -1; acc1 = -1; w = 0;
        load_valid = 1'b1;
        load_data  = 16'h1111;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            r = load_ready;
            exp_r = (c == 0 || c == 16 || c >= 32);
            n_vec++;
            if (r !== exp_r) begin
                n_err++;
                $display("FAIL b2b_ready c=%0d got=%b required=%b", c, r, exp_r);
            end
            if (c >= 16) begin
                n_vec++;
                if (digit !== ((c >= 32) ? 4'h2 : 4'h1)) begin
                    n_err++;
                    $display("FAIL b2b_digit c=%0d got=%h required=%h", c, digit, (c >= 32) ? 4'h2 : 4'h1);
                end
            end
            step();
            if (load_valid && r) begin
                if (w == 0) begin
                    acc0 = c; w = 1; load_data = 16'h2222;
                end else begin
                    acc1 = c; w = 2; load_valid = 1'b0;
                end
            end
        end
        load_valid = 1'b0;
        n_vec++;
        if (acc0 != 0 || acc1 != 16) begin
            n_err++;
            $display("FAIL b2b_accept cycles got=%0d,%0d required=0,16", acc0, acc1);
        end
    endtask

    task automatic test_enable_low();
        load_word(16'h5678);
        en = 1'b0;
        #1;
        n_vec++;
        if ({sel_a, sel_b, digit, blank, load_ready} !== {2'b10, 4'h2, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL en_drop {sel,digit,blank,ready} got=%b required=%b",
                     {sel_a, sel_b, digit, blank, load_ready}, {2'b10, 4'h2, 1'b1, 1'b0});
        end
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if ({sel_a, sel_b, digit, blank, frame_tick, load_ready} !== {2'b10, 4'h6, 1'b1, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL en_hold k=%0d got=%b required=%b", k,
                         {sel_a, sel_b, digit, blank, frame_tick, load_ready}, {2'b10, 4'h6, 1'b1, 1'b0, 1'b1});
            end
        end
        step();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if ({sel_a, sel_b, digit, blank} !== ((k < 3) ? {2'b10, 4'h6, 1'b0} : {2'b11, 4'h5, 1'b1})) begin
                n_err++;
                $display("FAIL en_resume k=%0d {sel,digit,blank} got=%b required=%b", k,
                         {sel_a, sel_b, digit, blank}, (k < 3) ? {2'b10, 4'h6, 1'b0} : {2'b11, 4'h5, 1'b1});
            end
        end
        step();
    endtask

    task automatic test_blank0();
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_vec++;
            if (b0_blank !== 1'b0) begin
                n_err++;
                $display("FAIL blank0 k=%0d got=%b required=0", k, b0_blank);
            end
        end
        step();
        en = 1'b0;
        #1;
        n_vec++;
        if (b0_blank !== 1'b1) begin
            n_err++;
            $display("FAIL blank0_en_low got=%b required=1", b0_blank);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_reset_mid();
        test_frame_commit();
        test_back_to_back();
        test_enable_low();
        test_blank0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
